// File: rtl/ram_responder_pkg.sv
// Shared types and helpers for the ram_responder word memory and its read pipeline.
// DATA_WIDTH normally arrives from the shared globalVariables.v include; the guard only fills the gap when it is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ram_responder_pkg;

    localparam int LANE_BITS = 8;
    localparam int LANES     = `DATA_WIDTH / LANE_BITS;

    typedef struct packed {
        logic                   valid;
        logic                   fault;
        logic [`DATA_WIDTH-1:0] data;
    } read_entry_t;

    // True when no address bit above the word-index field is set.
    function automatic logic addr_in_range(input logic [`DATA_WIDTH-1:0] addr,
                                           input int                     index_bits);
        return (addr >> (index_bits + 2)) == '0;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Fixed-depth load-return pipeline moving valid, fault and data together.
// Data in each stage only advances behind a valid entry, so the tail holds the last returned word.
module ram_read_pipe
    import ram_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  read_entry_t in_entry,
    output read_entry_t out_entry
);

    logic [DEPTH-1:0]                  valid_q;
    logic [DEPTH-1:0]                  fault_q;
    logic [DEPTH-1:0][`DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            fault_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= in_entry.valid;
            fault_q[0] <= in_entry.fault;
            if (in_entry.valid) begin
                data_q[0] <= in_entry.data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                fault_q[i] <= fault_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_entry.valid = valid_q[DEPTH-1];
    assign out_entry.fault = fault_q[DEPTH-1];
    assign out_entry.data  = data_q[DEPTH-1];

endmodule

// File: rtl/ram_responder.sv
// Byte-enabled word memory answering loads after a fixed latency, with out-of-range fault pulses.
// Reads sample the array at acceptance, so a same-cycle store to the same word is seen only by later loads.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`DATA_WIDTH-1:0] address,
    input  logic [`DATA_WIDTH-1:0] ramDataWrite,
    input  logic [3:0]             byteSelect,
    input  logic                   ramStore,
    input  logic                   ramLoad,
    output logic [`DATA_WIDTH-1:0] ramDataRead,
    output logic                   ramReadValid,
    output logic                   accessFault
);

    localparam int INDEX_BITS = $clog2(DEPTH_WORDS);

    logic [`DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [INDEX_BITS-1:0]  word_index;
    logic [`DATA_WIDTH-1:0] read_word;
    logic                   in_range;
    logic                   store_go;
    logic                   load_go;
    logic                   store_fault_q;
    read_entry_t            load_entry;
    read_entry_t            result_entry;

    assign word_index = address[INDEX_BITS+1:2];
    assign in_range   = addr_in_range(address, INDEX_BITS);
    assign store_go   = ramStore & ~reset & in_range;
    assign load_go    = ramLoad & ~reset;
    assign read_word  = mem[word_index];

    // Per-lane write enables keep this inferable as byte-enabled block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_go) begin
            for (int lane = 0; lane < LANES; lane++) begin
                if (byteSelect[lane]) begin
                    mem[word_index][lane*LANE_BITS +: LANE_BITS] <= ramDataWrite[lane*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_fault_q <= 1'b0;
        end else begin
            store_fault_q <= ramStore & ~in_range;
        end
    end

    always_comb begin
        load_entry.valid = load_go;
        load_entry.fault = load_go & ~in_range;
        load_entry.data  = (load_go & in_range) ? read_word : '0;
    end

    ram_read_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_read_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_entry (load_entry),
        .out_entry(result_entry)
    );

    assign ramReadValid = result_entry.valid;
    assign ramDataRead  = result_entry.data;
    assign accessFault  = result_entry.fault | store_fault_q;

endmodule
